// File: rtl/branch_pkg.sv
// Shared types and constants for branch resolution and the bimodal predictor.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  function automatic int tag_w(input int idx_w);
    return 32 - idx_w - 2;
  endfunction

  function automatic int table_depth(input int idx_w);
    return 1 << idx_w;
  endfunction

  // Saturating step of a 2-bit bimodal counter.
  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    if (taken) begin
      return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
    end
    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_btb.sv
// Direct-mapped BTB plus 2-bit bimodal history table: one combinational
// lookup port for IF and one write port for EX resolution.
module branch_btb
  import branch_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [31:0] rd_pc,
  output logic        rd_taken,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic        wr_jump,
  input  logic        wr_taken,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target
);

  localparam int TAG_W = tag_w(IDX_W);
  localparam int DEPTH = table_depth(IDX_W);

  logic             valid_reg  [DEPTH];
  logic [TAG_W-1:0] tag_reg    [DEPTH];
  logic [31:0]      target_reg [DEPTH];
  ctr_t             ctr_reg    [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  ctr_t             rd_ctr;

  assign rd_idx    = rd_pc[IDX_W+1:2];
  assign wr_idx    = wr_pc[IDX_W+1:2];
  assign rd_ctr    = ctr_reg[rd_idx];
  assign rd_target = target_reg[rd_idx];
  assign rd_taken  = valid_reg[rd_idx] && (tag_reg[rd_idx] == rd_pc[31:IDX_W+2]) && rd_ctr[1];

  // Reads see the pre-edge contents, so a same-index write is not bypassed.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        ctr_reg[i]    <= CTR_WNT;
      end
    end else if (wr_en) begin
      ctr_reg[wr_idx] <= wr_jump ? CTR_ST : ctr_step(ctr_reg[wr_idx], wr_taken);
      if (wr_taken) begin
        valid_reg[wr_idx]  <= 1'b1;
        tag_reg[wr_idx]    <= wr_pc[31:IDX_W+2];
        target_reg[wr_idx] <= wr_target;
      end
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution: outcome decode, mispredict detection,
// redirect generation, predictor training and resolve/mispredict statistics.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_if_pc,
  output logic        o_if_pred_taken,
  output logic [31:0] o_if_pred_target,
  input  logic        i_ex_valid,
  input  logic        i_ex_stall,
  input  logic        i_ex_is_branch,
  input  logic        i_ex_is_jump,
  input  logic [2:0]  i_ex_funct3,
  output logic        o_br_un,
  input  logic        i_br_equal,
  input  logic        i_br_less,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_illegal_br,
  output logic [31:0] o_br_count,
  output logic [31:0] o_miss_count
);

  logic        active;
  logic        cond_taken;
  logic        funct3_bad;
  logic        actual_taken;
  logic        mispredict;
  logic [31:0] br_count_reg;
  logic [31:0] miss_count_reg;

  always_comb begin
    cond_taken = 1'b0;
    funct3_bad = 1'b0;
    case (i_ex_funct3)
      F3_BEQ:           cond_taken = i_br_equal;
      F3_BNE:           cond_taken = ~i_br_equal;
      F3_BLT, F3_BLTU:  cond_taken = i_br_less;
      F3_BGE, F3_BGEU:  cond_taken = ~i_br_less;
      default:          funct3_bad = 1'b1;
    endcase
  end

  assign active       = i_ex_valid & ~i_ex_stall & (i_ex_is_branch | i_ex_is_jump);
  assign actual_taken = i_ex_is_jump | cond_taken;
  assign o_illegal_br = active & ~i_ex_is_jump & funct3_bad;
  assign o_br_un      = i_ex_funct3[1];

  // A correct direction with a stale target is still a mispredict.
  assign mispredict = active & ((actual_taken != i_ex_pred_taken) |
                                (actual_taken & (i_ex_pred_target != i_ex_target)));

  assign o_redirect    = mispredict;
  assign o_redirect_pc = actual_taken ? i_ex_target : i_ex_pc + 32'd4;

  branch_btb #(
    .IDX_W(IDX_W)
  ) u_btb (
    .clk       (i_clk),
    .srst      (i_rst),
    .rd_pc     (i_if_pc),
    .rd_taken  (o_if_pred_taken),
    .rd_target (o_if_pred_target),
    .wr_en     (active & ~o_illegal_br),
    .wr_jump   (i_ex_is_jump),
    .wr_taken  (actual_taken),
    .wr_pc     (i_ex_pc),
    .wr_target (i_ex_target)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      br_count_reg   <= '0;
      miss_count_reg <= '0;
    end else begin
      if (active && br_count_reg != '1) begin
        br_count_reg <= br_count_reg + 32'd1;
      end
      if (mispredict && miss_count_reg != '1) begin
        miss_count_reg <= miss_count_reg + 32'd1;
      end
    end
  end

  assign o_br_count   = br_count_reg;
  assign o_miss_count = miss_count_reg;

endmodule
